cpu_trace_buffer: RTL and testbench

//  Downstream debug consumer of the integrated CPU top level. Snoops CurrentState, PCOut and IROut.

---
 rtl/cpu_trace_buffer_if.sv | 9 +
 rtl/cpu_trace_buffer.sv | 100 ++++++++++
 tb/tb_cpu_trace_buffer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_buffer_if.sv
// rtl/cpu_trace_buffer_if.sv - host read port of the CPU trace buffer
interface cpu_trace_buffer_if;
    logic        RdValid;
    logic        RdReady;
    logic [31:0] RdData;

    modport master (output RdValid, output RdData, input RdReady);
    modport slave  (input RdValid, input RdData, output RdReady);
endinterface

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - records {PC, IR} on each decode-state entry into a drainable FIFO
module cpu_trace_buffer #(
    parameter int          ADDR_W        = 4,
    parameter logic [4:0]  CAPTURE_STATE = 5'd1
) (
    input  logic                CLK,
    input  logic                RstN,
    input  logic [4:0]          CurrentState,
    input  logic [15:0]         PCIn,
    input  logic [15:0]         IRIn,
    input  logic                Enable,
    input  logic                TrigEn,
    input  logic [15:0]         TrigPC,
    input  logic                WrapMode,
    input  logic                Clear,
    cpu_trace_buffer_if.master  rd,
    output logic [ADDR_W:0]     Count,
    output logic                Overflow,
    output logic [1:0]          TraceState
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, CAPTURING = 2'b10, STOPPED = 2'b11} state_t;

    state_t              state, stateNext;
    logic [4:0]          prevState;
    logic [31:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   wrPtr, rdPtr;
    logic                evt, full, empty, pop;
    logic                capture, dropEntry, doWrite, advanceRd, countInc, ovfSet;

    assign evt   = (CurrentState == CAPTURE_STATE) && (prevState != CAPTURE_STATE);
    assign full  = (Count == (ADDR_W + 1)'(DEPTH));
    assign empty = (Count == '0);
    assign pop   = !empty && rd.RdReady;

    always_comb begin
        stateNext = state;
        capture   = 1'b0;
        if (Clear || !Enable) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:      stateNext = TrigEn ? ARMED : CAPTURING;
                ARMED: begin
                    if (evt && (PCIn == TrigPC)) begin
                        capture   = 1'b1;
                        stateNext = CAPTURING;
                    end
                end
                CAPTURING: capture = evt;
                STOPPED:   stateNext = STOPPED;
                default:   stateNext = IDLE;
            endcase
        end
        // A capture into a full FIFO with nothing leaving and no wrap is lost and tracing halts
        if (capture && full && !pop && !WrapMode)
            stateNext = STOPPED;
    end

    assign dropEntry = capture && full && !pop && !WrapMode;
    assign doWrite   = capture && !dropEntry;
    assign advanceRd = pop || (doWrite && full);
    assign countInc  = doWrite && (!full || pop);
    assign ovfSet    = capture && full && !pop;

    always_ff @(posedge CLK) begin
        if (!RstN) begin
            state     <= IDLE;
            prevState <= CAPTURE_STATE;
            wrPtr     <= '0;
            rdPtr     <= '0;
            Count     <= '0;
            Overflow  <= 1'b0;
        end else begin
            state     <= stateNext;
            prevState <= CurrentState;
            if (Clear) begin
                wrPtr    <= '0;
                rdPtr    <= '0;
                Count    <= '0;
                Overflow <= 1'b0;
            end else begin
                if (doWrite)   wrPtr <= wrPtr + 1'b1;
                if (advanceRd) rdPtr <= rdPtr + 1'b1;
                Count <= Count + (ADDR_W + 1)'(countInc) - (ADDR_W + 1)'(pop);
                if (ovfSet)    Overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RstN && doWrite)
            mem[wrPtr] <= {PCIn, IRIn};
    end

    assign rd.RdValid = !empty;
    assign rd.RdData  = empty ? 32'h0 : mem[rdPtr];
    assign TraceState = state;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - scoreboard bench for cpu_trace_buffer
module tb_cpu_trace_buffer;
    localparam logic [4:0] CAP   = 5'd1;
    localparam int         DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RstN, Enable, TrigEn, WrapMode, Clear;
    logic [4:0]  CurrentState;
    logic [15:0] PCIn, IRIn, TrigPC;
    logic [4:0]  Count;
    logic        Overflow;
    logic [1:0]  TraceState;

    cpu_trace_buffer_if rdIf();

    always #5 CLK = ~CLK;

    cpu_trace_buffer #(.ADDR_W(4), .CAPTURE_STATE(CAP)) dut (
        .CLK(CLK), .RstN(RstN), .CurrentState(CurrentState), .PCIn(PCIn), .IRIn(IRIn),
        .Enable(Enable), .TrigEn(TrigEn), .TrigPC(TrigPC), .WrapMode(WrapMode), .Clear(Clear),
        .rd(rdIf.master), .Count(Count), .Overflow(Overflow), .TraceState(TraceState)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, trace mode as spec state code
    logic [31:0] q[$];
    int          mst   = 0;
    bit          movf  = 0;
    logic [4:0]  mprev = CAP;
    bit          monOn = 0;

    always @(posedge CLK) begin : model
        bit evt, pop, wasFull, attempt;
        if (!RstN) begin
            q.delete();
            mst   = 0;
            movf  = 0;
            mprev = CAP;
        end else begin
            evt   = (CurrentState == CAP) && (mprev != CAP);
            mprev = CurrentState;
            if (Clear) begin
                q.delete();
                mst  = 0;
                movf = 0;
            end else begin
                wasFull = (q.size() == DEPTH);
                pop     = (q.size() > 0) && rdIf.RdReady;
                attempt = 0;
                if (pop) void'(q.pop_front());
                if (!Enable) mst = 0;
                else begin
                    case (mst)
                        0: mst = TrigEn ? 1 : 2;
                        1: if (evt && PCIn == TrigPC) begin attempt = 1; mst = 2; end
                        2: attempt = evt;
                        default: ;
                    endcase
                end
                if (attempt) begin
                    if (!wasFull || pop) q.push_back({PCIn, IRIn});
                    else begin
                        movf = 1;
                        if (WrapMode) begin
                            void'(q.pop_front());
                            q.push_back({PCIn, IRIn});
                        end else mst = 3;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (monOn) begin
            check("count", 32'(Count), 32'(q.size()));
            check("valid", 32'(rdIf.RdValid), 32'(q.size() > 0));
            check("overflow", 32'(Overflow), 32'(movf));
            check("state", 32'(TraceState), 32'(mst));
            if (q.size() == 0) check("rddata_empty", rdIf.RdData, 32'h0);
            else if (rdIf.RdValid && rdIf.RdReady) check("pop_data", rdIf.RdData, q[0]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic decode(input logic [15:0] pc, input logic [15:0] ir, input logic rdy);
        CurrentState = CAP;
        PCIn = pc;
        IRIn = ir;
        rdIf.RdReady = rdy;
        tick();
        CurrentState = 5'd2;
        rdIf.RdReady = 1'b0;
        tick();
    endtask

    task automatic restartClear(input logic wrap);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        WrapMode = wrap;
        tick();
    endtask

    initial begin
        RstN = 1'b0; Enable = 1'b0; TrigEn = 1'b0; WrapMode = 1'b0; Clear = 1'b0;
        CurrentState = 5'd0; PCIn = '0; IRIn = '0; TrigPC = '0; rdIf.RdReady = 1'b0;
        tick(); tick();
        RstN = 1'b1;
        monOn = 1;
        check("rst_count", 32'(Count), 0);
        check("rst_valid", 32'(rdIf.RdValid), 0);
        check("rst_data", rdIf.RdData, 0);
        check("rst_state", 32'(TraceState), 0);
        check("rst_ovf", 32'(Overflow), 0);

        // basic capture and drain
        Enable = 1'b1;
        tick();
        decode(16'h0000, 16'h1111, 0);
        decode(16'h0002, 16'h2222, 0);
        decode(16'h0004, 16'h3333, 0);
        check("t1_count", 32'(Count), 3);
        check("t1_d0", rdIf.RdData, 32'h00001111);
        rdIf.RdReady = 1'b1;
        tick();
        check("t1_d1", rdIf.RdData, 32'h00022222);
        tick();
        check("t1_d2", rdIf.RdData, 32'h00043333);
        tick();
        rdIf.RdReady = 1'b0;
        check("t1_empty", 32'(rdIf.RdValid), 0);

        // held decode state yields one entry
        CurrentState = CAP; PCIn = 16'h0040; IRIn = 16'h4444;
        repeat (4) tick();
        CurrentState = 5'd2;
        tick();
        check("t2_count", 32'(Count), 1);
        rdIf.RdReady = 1'b1;
        tick();
        rdIf.RdReady = 1'b0;

        // PC trigger
        Enable = 1'b0;
        tick();
        Enable = 1'b1; TrigEn = 1'b1; TrigPC = 16'h0010;
        tick();
        check("t3_armed", 32'(TraceState), 1);
        decode(16'h000C, 16'h0C0C, 0);
        decode(16'h000E, 16'h0E0E, 0);
        check("t3_still_armed", 32'(TraceState), 1);
        check("t3_none", 32'(Count), 0);
        decode(16'h0010, 16'h1010, 0);
        check("t3_capturing", 32'(TraceState), 2);
        decode(16'h0012, 16'h1212, 0);
        check("t3_count", 32'(Count), 2);
        check("t3_first", rdIf.RdData, 32'h00101010);
        rdIf.RdReady = 1'b1;
        tick(); tick();
        rdIf.RdReady = 1'b0;
        TrigEn = 1'b0;

        // stop on full
        restartClear(1'b0);
        for (int i = 0; i < DEPTH + 1; i++) decode(16'h0100 + 16'(i), 16'(i), 0);
        check("t4_count", 32'(Count), 16);
        check("t4_ovf", 32'(Overflow), 1);
        check("t4_state", 32'(TraceState), 3);
        check("t4_oldest", rdIf.RdData, 32'h01000000);

        // wrap mode
        restartClear(1'b1);
        check("t5_cleared_ovf", 32'(Overflow), 0);
        for (int i = 0; i < 18; i++) decode(16'(i), 16'hA000 + 16'(i), 0);
        check("t5_count", 32'(Count), 16);
        check("t5_ovf", 32'(Overflow), 1);
        check("t5_oldest", rdIf.RdData, 32'h0002A002);
        decode(16'h0055, 16'h5555, 1);
        check("t5_fullpop_count", 32'(Count), 16);
        check("t5_fullpop_ovf", 32'(Overflow), 1);
        check("t5_fullpop_head", rdIf.RdData, 32'h0003A003);

        // full + evt + pop without wrap: no overflow, keeps capturing
        restartClear(1'b0);
        for (int i = 0; i < DEPTH; i++) decode(16'h0200 + 16'(i), 16'(i), 0);
        decode(16'h0300, 16'h0300, 1);
        check("t5b_count", 32'(Count), 16);
        check("t5b_ovf", 32'(Overflow), 0);
        check("t5b_state", 32'(TraceState), 2);

        // reset mid-capture, then Clear racing an event
        restartClear(1'b0);
        for (int i = 0; i < 5; i++) decode(16'h0400 + 16'(i), 16'(i), 0);
        RstN = 1'b0;
        tick();
        RstN = 1'b1;
        check("t6_valid", 32'(rdIf.RdValid), 0);
        check("t6_count", 32'(Count), 0);
        check("t6_data", rdIf.RdData, 0);
        check("t6_state", 32'(TraceState), 0);
        tick();
        decode(16'h0500, 16'h0001, 0);
        decode(16'h0502, 16'h0002, 0);
        Clear = 1'b1; CurrentState = CAP; PCIn = 16'h0504;
        tick();
        Clear = 1'b0; CurrentState = 5'd2;
        tick();
        check("t6_clear_evt", 32'(Count), 0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                WrapMode = 1'($urandom_range(0, 1));
                TrigEn   = 1'($urandom_range(0, 1));
                TrigPC   = 16'($urandom_range(0, 7) * 2);
            end
            CurrentState = 5'($urandom_range(0, 2));
            PCIn         = 16'($urandom_range(0, 7) * 2);
            IRIn         = 16'($urandom);
            rdIf.RdReady = ($urandom_range(0, 99) < 35);
            Enable       = ($urandom_range(0, 99) < 97);
            Clear        = ($urandom_range(0, 199) == 0);
            RstN         = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
